// File: rtl/mac_ifmaps_line_buffer_pkg.sv
// Shared types and constants for the ifmaps line buffer that feeds the
// 5-row MAC ifmaps FIFO.
package mac_ifmaps_line_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } lb_state_e;

  localparam int MIN_ROWS    = 5;
  localparam int NUM_LB_ROWS = 4;

  // Ceiling log2; the address width needed to index 'value' entries.
  function automatic int clogb2(input int value);
    int v;
    int result;
    v = value - 1;
    result = 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_lb_row_mem.sv
// One line-buffer row: register array with asynchronous read and
// synchronous write with enable.
module mac_lb_row_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset on purpose; every location is rewritten during
  // FILL before it can reach an output, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mac_ifmaps_line_buffer.sv
// Raster pixel stream in, 5-pixel vertical columns (rows r-4..r) out, using
// the ifmaps FIFO's valid/full pair as the downstream handshake.
module mac_ifmaps_line_buffer
  import mac_ifmaps_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_COLS   = 32,
  parameter int ROW_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [clogb2(MAX_COLS):0]       cfg_cols,
  input  logic [ROW_W-1:0]                cfg_rows,
  input  logic [DATA_WIDTH-1:0]           pix_data,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [DATA_WIDTH-1:0]           ifmaps_fifo_row0_in,
  output logic [DATA_WIDTH-1:0]           ifmaps_fifo_row1_in,
  output logic [DATA_WIDTH-1:0]           ifmaps_fifo_row2_in,
  output logic [DATA_WIDTH-1:0]           ifmaps_fifo_row3_in,
  output logic [DATA_WIDTH-1:0]           ifmaps_fifo_row4_in,
  output logic                            ifmaps_input_valid,
  input  logic                            fifo_full,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_error
);

  localparam int AW = clogb2(MAX_COLS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    MAX_COLS_C  = CW'(MAX_COLS);
  localparam logic [ROW_W-1:0] MIN_ROWS_C  = ROW_W'(MIN_ROWS);
  localparam logic [ROW_W-1:0] LAST_FILL_C = ROW_W'(NUM_LB_ROWS - 1);

  lb_state_e         state_q, state_d;
  logic [AW-1:0]     col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CW-1:0]     cols_q, cols_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              err_q, err_d;
  logic              accept, col_last, row_last, cfg_bad;

  logic [DATA_WIDTH-1:0] lb_rd [NUM_LB_ROWS];
  logic [DATA_WIDTH-1:0] lb_wr [NUM_LB_ROWS];

  assign cfg_bad  = (cfg_rows < MIN_ROWS_C) || (cfg_cols == '0) || (cfg_cols > MAX_COLS_C);
  assign col_last = ({1'b0, col_q} == cols_q - CW'(1));
  assign row_last = (row_q == rows_q - ROW_W'(1));

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d            = state_q;
    col_d              = col_q;
    row_d              = row_q;
    cols_d             = cols_q;
    rows_d             = rows_q;
    err_d              = err_q;
    pix_ready          = 1'b0;
    ifmaps_input_valid = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    cfg_error          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cols_d  = cfg_cols;
          rows_d  = cfg_rows;
          col_d   = '0;
          row_d   = '0;
          err_d   = cfg_bad;
          state_d = cfg_bad ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        busy      = 1'b1;
        pix_ready = 1'b1;
      end
      ST_STREAM: begin
        busy               = 1'b1;
        pix_ready          = ~fifo_full;
        ifmaps_input_valid = pix_valid & ~fifo_full;
      end
      ST_DONE: begin
        done      = 1'b1;
        cfg_error = err_q;
        err_d     = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    accept = pix_valid & pix_ready;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
        if (state_q == ST_FILL && row_q == LAST_FILL_C) state_d = ST_STREAM;
        if (state_q == ST_STREAM && row_last)           state_d = ST_DONE;
      end else begin
        col_d = col_q + AW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      err_q   <= err_d;
    end
  end

  // Each row shifts one step older on accept: row k takes row k+1's pixel,
  // the youngest row takes the incoming pixel.
  for (genvar k = 0; k < NUM_LB_ROWS; k++) begin : g_row
    if (k == NUM_LB_ROWS - 1) begin : g_top
      assign lb_wr[k] = pix_data;
    end else begin : g_mid
      assign lb_wr[k] = lb_rd[k+1];
    end

    mac_lb_row_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_COLS),
      .AW         (AW)
    ) u_mem (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q),
      .wdata (lb_wr[k]),
      .rdata (lb_rd[k])
    );
  end

  assign ifmaps_fifo_row0_in = ifmaps_input_valid ? lb_rd[0] : '0;
  assign ifmaps_fifo_row1_in = ifmaps_input_valid ? lb_rd[1] : '0;
  assign ifmaps_fifo_row2_in = ifmaps_input_valid ? lb_rd[2] : '0;
  assign ifmaps_fifo_row3_in = ifmaps_input_valid ? lb_rd[3] : '0;
  assign ifmaps_fifo_row4_in = ifmaps_input_valid ? pix_data : '0;

endmodule

// File: tb/tb_mac_ifmaps_line_buffer.sv
// Directed and randomized bench for mac_ifmaps_line_buffer; expected columns
// come from a frame image held in an array.
module tb_mac_ifmaps_line_buffer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  cfg_cols;
  logic [15:0] cfg_rows;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_ready, fifo_full;
  logic [7:0]  row0, row1, row2, row3, row4;
  logic        ifmaps_input_valid, busy, done, cfg_error;

  mac_ifmaps_line_buffer #(.DATA_WIDTH(8), .MAX_COLS(32), .ROW_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .cfg_cols            (cfg_cols),
    .cfg_rows            (cfg_rows),
    .pix_data            (pix_data),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .ifmaps_fifo_row0_in (row0),
    .ifmaps_fifo_row1_in (row1),
    .ifmaps_fifo_row2_in (row2),
    .ifmaps_fifo_row3_in (row3),
    .ifmaps_fifo_row4_in (row4),
    .ifmaps_input_valid  (ifmaps_input_valid),
    .fifo_full           (fifo_full),
    .busy                (busy),
    .done                (done),
    .cfg_error           (cfg_error)
  );

  always #5 clk = ~clk;

  localparam int CYC_LIMIT = 4000;

  int total = 0;
  int bad   = 0;

  logic [7:0]  img [0:15][0:31];
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int pr, pc, ncols;
  int hs_viol, zero_viol, done_early;
  logic last_ready, last_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] cur_col();
    return {row0, row1, row2, row3, row4};
  endfunction

  function automatic logic [39:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 40'hFF_FFFF_FFFF;
  endfunction

  task automatic do_start(input int cols, input int rows);
    cfg_cols  = 6'(cols);
    cfg_rows  = 16'(rows);
    start     = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One clock of stimulus; advances the bench's pixel cursor on acceptance.
  task automatic step(input bit vld, input bit ff, input bit st);
    bit acc, exp_ready;
    pix_valid = vld;
    fifo_full = ff;
    pix_data  = img[pr][pc];
    if (st) begin
      start    = 1'b1;
      cfg_cols = 6'd2;
      cfg_rows = 16'd20;
    end
    exp_ready = (pr < 4) ? 1'b1 : !ff;
    @(negedge clk);
    last_ready = pix_ready;
    last_valid = ifmaps_input_valid;
    if (pix_ready !== exp_ready) hs_viol++;
    if (ifmaps_input_valid !== (vld && !ff && pr >= 4)) hs_viol++;
    if (busy !== 1'b1) hs_viol++;
    if (done !== 1'b0) done_early++;
    if (ifmaps_input_valid) got_q.push_back(cur_col());
    else if (cur_col() !== 40'h0) zero_viol++;
    acc = vld && pix_ready;
    @(posedge clk); #1;
    start = 1'b0;
    if (acc) begin
      if (pc == ncols - 1) begin
        pc = 0;
        pr++;
      end else begin
        pc++;
      end
    end
  endtask

  // mode: 0 = r*16+c, 1 = all 0xAA, 2 = random pixels.
  task automatic run_frame(input int cols, input int rows, input int mode,
                           input int pv, input int pf, input bit stall,
                           input int abort_r, input int abort_c,
                           input int st_r, input int st_c, output bit aborted);
    int cyc, stall_used, mism;
    bit vld, ff, st, st_used;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        img[r][c] = (mode == 0) ? 8'(r * 16 + c) : (mode == 1) ? 8'hAA : 8'($urandom_range(0, 255));
    exp_q.delete();
    got_q.delete();
    for (int r = 4; r < rows; r++)
      for (int c = 0; c < cols; c++)
        exp_q.push_back({img[r-4][c], img[r-3][c], img[r-2][c], img[r-1][c], img[r][c]});
    ncols = cols; pr = 0; pc = 0;
    hs_viol = 0; zero_viol = 0; done_early = 0;
    stall_used = 0; st_used = 0; aborted = 0; cyc = 0;
    do_start(cols, rows);
    while (pr < rows && cyc < CYC_LIMIT) begin
      if (pr == abort_r && pc == abort_c) begin
        aborted = 1;
        break;
      end
      vld = ($urandom_range(0, 99) < pv);
      ff  = ($urandom_range(0, 99) < pf);
      st  = 0;
      if (stall && pr == 5 && pc == 1 && stall_used < 3) begin
        vld = 1; ff = 1;
      end
      if (!st_used && pr == st_r && pc == st_c) begin
        st = 1; st_used = 1;
      end
      step(vld, ff, st);
      if (stall && ff && pr == 5 && pc == 1 && stall_used < 3) begin
        stall_used++;
        check("stall_ready", 64'(last_ready), 64'd0);
        check("stall_valid", 64'(last_valid), 64'd0);
      end
      cyc++;
    end
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    if (aborted) return;
    check("frame_timeout", 64'(cyc < CYC_LIMIT), 64'd1);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("done_no_err", 64'(cfg_error), 64'd0);
    check("done_not_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    @(posedge clk); #1;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (got_at(i) !== exp_q[i]) mism++;
    check("col_count", 64'(got_q.size()), 64'(exp_q.size()));
    check("col_data_mismatches", 64'(mism), 64'd0);
    check("handshake_viol", 64'(hs_viol), 64'd0);
    check("zero_force_viol", 64'(zero_viol), 64'd0);
    check("done_early", 64'(done_early), 64'd0);
  endtask

  task automatic illegal_cfg(input string tag, input int cols, input int rows);
    pix_valid = 1'b1;
    do_start(cols, rows);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(cfg_error), 64'd1);
    check({tag, "_ready"}, 64'(pix_ready), 64'd0);
    check({tag, "_valid"}, 64'(ifmaps_input_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_clear"}, 64'({done, cfg_error, pix_ready, busy}), 64'd0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  initial begin
    bit ab;
    int aa_hits, dcnt;
    rst = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0;
    pix_data = 8'h5A; pix_valid = 1'b1; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_ctrl", 64'({ifmaps_input_valid, busy, done, cfg_error}), 64'd0);
    check("rst_rows", 64'(cur_col()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;

    // Test 1: plain 4x6 frame.
    run_frame(4, 6, 0, 100, 0, 0, -1, -1, -1, -1, ab);
    check("t1_count", 64'(got_q.size()), 64'd8);
    check("t1_first", 64'(got_at(0)), 64'h00_1020_3040);
    check("t1_last", 64'(got_at(7)), 64'h13_2333_4353);

    // Test 2: three-cycle backpressure at row 5 col 1.
    run_frame(4, 6, 0, 100, 0, 1, -1, -1, -1, -1, ab);
    check("t2_count", 64'(got_q.size()), 64'd8);
    check("t2_resume", 64'(got_at(5)), 64'h11_2131_4151);

    // Test 3: illegal configurations.
    illegal_cfg("t3_rows4", 4, 4);
    illegal_cfg("t3_cols0", 0, 6);
    illegal_cfg("t3_cols33", 33, 6);

    // Test 4: reset mid-frame, then a fresh 3x5 frame.
    run_frame(4, 6, 0, 100, 0, 0, 5, 2, -1, -1, ab);
    check("t4_reached_abort", 64'(ab), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    @(negedge clk);
    check("t4_busy_after_rst", 64'(busy), 64'd0);
    check("t4_ready_after_rst", 64'(pix_ready), 64'd0);
    if (done) dcnt++;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t4_no_done", 64'(dcnt), 64'd0);
    @(posedge clk); #1;
    run_frame(3, 5, 0, 100, 0, 0, -1, -1, -1, -1, ab);
    check("t4_count", 64'(got_q.size()), 64'd3);

    // Test 5: stale 0xAA frame must never leak into the next frame.
    run_frame(4, 6, 1, 100, 0, 0, -1, -1, -1, -1, ab);
    run_frame(4, 6, 0, 80, 20, 0, -1, -1, -1, -1, ab);
    aa_hits = 0;
    foreach (got_q[i])
      for (int b = 0; b < 5; b++)
        if (got_q[i][b*8 +: 8] == 8'hAA) aa_hits++;
    check("t5_no_stale", 64'(aa_hits), 64'd0);

    // Test 6: start pulses mid-frame are ignored.
    run_frame(4, 6, 0, 100, 0, 0, -1, -1, 4, 2, ab);
    check("t6_stream_count", 64'(got_q.size()), 64'd8);
    run_frame(4, 6, 0, 100, 0, 0, -1, -1, 1, 0, ab);
    check("t6_fill_count", 64'(got_q.size()), 64'd8);

    // Randomized frames, including the 1-column and MAX_COLS widths.
    run_frame(1, 7, 2, 70, 30, 0, -1, -1, -1, -1, ab);
    run_frame(32, 6, 2, 70, 30, 0, -1, -1, -1, -1, ab);
    repeat (4) begin
      run_frame($urandom_range(1, 32), $urandom_range(5, 10), 2, 70, 30, 0, -1, -1, -1, -1, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
